rocketcpu_wb_decoder: RTL

ROCKETCPU_WB_DECODER -- requirements
Module: rocketcpu_wb_decoder

---
 rtl/rocketcpu_pkg.sv | 37 +++
 rtl/rocketcpu_addr_match.sv | 31 +++
 rtl/rocketcpu_wb_decoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rocketcpu_pkg.sv
// Shared definitions for the rocketcpu Wishbone fabric: decoder state
// encoding, bus widths and the soc address map.
package rocketcpu_pkg;

   localparam int unsigned WB_AW     = 32;
   localparam int unsigned WB_DW     = 32;
   localparam int unsigned FAULT_CW  = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_ERR    = 2'd2,
      ST_DONE   = 2'd3
   } wb_dec_state_t;

   // soc address map: base/mask pairs, slave matches when (adr & MASK) == BASE
   localparam logic [31:0] RAM_BASE       = 32'h0000_0000;
   localparam logic [31:0] RAM_MASK       = 32'hFFFF_8000;
   localparam logic [31:0] FLASH_BASE     = 32'h0100_0000;
   localparam logic [31:0] FLASH_MASK     = 32'hFF00_0000;
   localparam logic [31:0] GPIO_BASE      = 32'h4000_0000;
   localparam logic [31:0] GPIO_MASK      = 32'hFFFF_FFF0;
   localparam logic [31:0] UART_BASE      = 32'h4000_1000;
   localparam logic [31:0] UART_MASK      = 32'hFFFF_FFF0;
   localparam logic [31:0] TIMER_BASE     = 32'h4000_2000;
   localparam logic [31:0] TIMER_MASK     = 32'hFFFF_FFF0;
   localparam logic [31:0] CODEC_SPI_BASE = 32'h4000_3000;
   localparam logic [31:0] CODEC_SPI_MASK = 32'hFFFF_FFF0;
   localparam logic [31:0] AUDIO_BASE     = 32'h4000_4000;
   localparam logic [31:0] AUDIO_MASK     = 32'hFFFF_FF00;

   // Width of a slave index; a single slave still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rocketcpu_addr_match.sv
// Address compare against every slave window plus a lowest-index-wins
// priority encoder.
module rocketcpu_addr_match
   import rocketcpu_pkg::*;
#(
   parameter int unsigned           NSLAVES = 6,
   parameter logic [NSLAVES*32-1:0] BASE    = '0,
   parameter logic [NSLAVES*32-1:0] MASK    = '0,
   parameter int unsigned           IW      = idx_width(NSLAVES)
) (
   input  logic [31:0]   adr,
   output logic          any_c,
   output logic [IW-1:0] idx_c
);

   logic [NSLAVES-1:0] hit;

   always_comb begin
      hit   = '0;
      idx_c = '0;
      for (int k = 0; k < int'(NSLAVES); k++) begin
         hit[k] = (adr & MASK[32*k +: 32]) == BASE[32*k +: 32];
      end
      // scan downwards so the lowest matching slave is the last one written
      for (int k = int'(NSLAVES) - 1; k >= 0; k--) begin
         if (hit[k]) idx_c = IW'(k);
      end
      any_c = |hit;
   end

endmodule

// File: rtl/rocketcpu_wb_decoder.sv
// Single-master Wishbone address decoder with auto-ack slaves, timeout
// bus errors and a fault address/count log.
module rocketcpu_wb_decoder
   import rocketcpu_pkg::*;
#(
   parameter int unsigned           NSLAVES = 6,
   parameter logic [NSLAVES*32-1:0] BASE    = '0,
   parameter logic [NSLAVES*32-1:0] MASK    = '0,
   parameter logic [NSLAVES-1:0]    AUTOACK = '0,
   parameter int unsigned           TIMEOUT = 255
) (
   input  logic                    i_wb_clk,
   input  logic                    reset,
   input  logic [31:0]             i_wb_adr,
   input  logic                    i_wb_cyc,
   output logic [31:0]             o_wb_rdt,
   output logic                    o_wb_ack,
   output logic                    o_wb_err,
   output logic [NSLAVES-1:0]      o_s_cyc,
   input  logic [NSLAVES*32-1:0]   i_s_rdt,
   input  logic [NSLAVES-1:0]      i_s_ack,
   output logic [31:0]             o_fault_adr,
   output logic [FAULT_CW-1:0]     o_fault_cnt
);

   localparam int unsigned    IW       = idx_width(NSLAVES);
   localparam int unsigned    CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit             TMO_EN   = (TIMEOUT != 0);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT);

   wb_dec_state_t  state;
   logic [IW-1:0]  idx;
   logic [CW-1:0]  cnt;

   logic           match_any;
   logic [IW-1:0]  match_idx;
   logic [31:0]    s_rdt [NSLAVES];
   logic           sel_ack;
   logic           tmo_hit;
   logic           err_rsp;

   rocketcpu_addr_match #(
      .NSLAVES (NSLAVES),
      .BASE    (BASE),
      .MASK    (MASK),
      .IW      (IW)
   ) u_match (
      .adr   (i_wb_adr),
      .any_c (match_any),
      .idx_c (match_idx)
   );

   always_comb begin
      for (int k = 0; k < int'(NSLAVES); k++) s_rdt[k] = i_s_rdt[32*k +: 32];
   end

   // A slave ack (real or automatic) beats a timeout landing in the same cycle.
   assign sel_ack = AUTOACK[idx] | i_s_ack[idx];
   assign tmo_hit = TMO_EN && (cnt == CNT_LAST);

   // Master-facing response; everything is held at zero while reset is high.
   always_comb begin
      o_wb_ack = 1'b0;
      o_wb_err = 1'b0;
      o_wb_rdt = '0;
      o_s_cyc  = '0;
      err_rsp  = 1'b0;
      if (!reset) begin
         unique case (state)
            ST_ACTIVE: begin
               if (i_wb_cyc) begin
                  if (sel_ack) begin
                     o_wb_ack     = 1'b1;
                     o_wb_rdt     = s_rdt[idx];
                     o_s_cyc[idx] = 1'b1;
                  end else if (tmo_hit) begin
                     o_wb_ack = 1'b1;
                     o_wb_err = 1'b1;
                     err_rsp  = 1'b1;
                  end else begin
                     o_s_cyc[idx] = 1'b1;
                  end
               end
            end
            ST_ERR: begin
               o_wb_ack = 1'b1;
               o_wb_err = 1'b1;
               err_rsp  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_wb_clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         cnt         <= '0;
         o_fault_adr <= '0;
         o_fault_cnt <= '0;
      end else begin
         if (err_rsp) begin
            o_fault_adr <= i_wb_adr;
            if (o_fault_cnt != 8'hFF) o_fault_cnt <= o_fault_cnt + 8'd1;
         end
         unique case (state)
            ST_IDLE: begin
               if (i_wb_cyc) begin
                  cnt <= '0;
                  if (match_any) begin
                     idx   <= match_idx;
                     state <= ST_ACTIVE;
                  end else begin
                     state <= ST_ERR;
                  end
               end
            end
            ST_ACTIVE: begin
               if (!i_wb_cyc)    state <= ST_IDLE;
               else if (o_wb_ack) state <= ST_DONE;
               else if (TMO_EN)   cnt   <= cnt + CW'(1);
            end
            ST_ERR:  state <= ST_DONE;
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
